// File: rtl/fft_coeff_seq_if.sv
// fft_coeff_seq_if: handshake/ROM bundle between the FFT stage controller and a
// twiddle-coefficient sequencer.
//   slave  : sequencer side (takes start/hold/cont, drives ROM + tag + status)
//   master : controller side
// Signals:
//   start, hold, cont                    controller requests
//   rom_addr[AW], rom_en                 ROM read port
//   coeff_valid, coeff_first, coeff_last ROM-latency aligned beat tags
//   busy, done                           sequence status
interface fft_coeff_seq_if #(
  parameter int AW = 5
);
  logic          start;
  logic          hold;
  logic          cont;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic          coeff_valid;
  logic          coeff_first;
  logic          coeff_last;
  logic          busy;
  logic          done;

  modport slave (
    input  start, hold, cont,
    output rom_addr, rom_en, coeff_valid, coeff_first, coeff_last, busy, done
  );

  modport master (
    output start, hold, cont,
    input  rom_addr, rom_en, coeff_valid, coeff_first, coeff_last, busy, done
  );
endinterface

// File: rtl/fft_coeff_seq.sv
// fft_coeff_seq: start/hold/done controlled read sequencer for one FFT
// twiddle-coefficient ROM. Issues SIZE reads (or continuous frames), stalls on
// hold without dropping/duplicating addresses, and delays valid/first/last by
// ROM_LAT so tags line up with ROM read data.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fft_coeff_seq_if.slave (start/hold/cont in; rom_addr/rom_en,
//        coeff_valid/first/last, busy/done out)
// Parameters: SIZE (power of two >= 2), AW = log2(SIZE), ROM_LAT (1..4).
// Option: define COEFF_SEQ_BITREV_EN to drive rom_addr with the bit-reversed
// counter (first/last still follow issue order).
module fft_coeff_seq #(
  parameter int SIZE    = 32,
  parameter int AW      = 5,
  parameter int ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  fft_coeff_seq_if.slave   bus
);
  localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_cnt, w_cnt_nxt;
  logic [ROM_LAT-1:0]   r_vld_pipe, r_first_pipe, r_last_pipe;
  logic                 w_issue, w_is_first, w_is_last;
  logic [AW-1:0]        w_addr;

  assign w_issue    = (r_state == S_RUN) && !bus.hold;
  assign w_is_first = (r_cnt == '0);
  assign w_is_last  = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
      S_RUN: if (w_issue) begin
        if (w_is_last) begin
          // cont is only looked at here, so dropping it mid-frame still
          // completes the frame; without cont the counter parks on SIZE-1.
          if (bus.cont) w_cnt_nxt   = '0;
          else          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_DRAIN: if (r_vld_pipe == '0) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tag pipeline: stage 0 is captured at issue, stage ROM_LAT-1 is the output.
  generate
    if (ROM_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_pipe   <= '0;
          r_first_pipe <= '0;
          r_last_pipe  <= '0;
        end else begin
          r_vld_pipe   <= w_issue;
          r_first_pipe <= w_issue && w_is_first;
          r_last_pipe  <= w_issue && w_is_last;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_pipe   <= '0;
          r_first_pipe <= '0;
          r_last_pipe  <= '0;
        end else begin
          r_vld_pipe   <= {r_vld_pipe[ROM_LAT-2:0],   w_issue};
          r_first_pipe <= {r_first_pipe[ROM_LAT-2:0], w_issue && w_is_first};
          r_last_pipe  <= {r_last_pipe[ROM_LAT-2:0],  w_issue && w_is_last};
        end
      end
    end
  endgenerate

`ifdef COEFF_SEQ_BITREV_EN
  // Decimation-in-time ordering: address bits mirrored from the issue counter.
  for (genvar g = 0; g < AW; g++) begin : g_rev
    assign w_addr[g] = r_cnt[AW-1-g];
  end
`else
  assign w_addr = r_cnt;
`endif

  assign bus.rom_addr    = w_addr;
  assign bus.rom_en      = w_issue;
  assign bus.coeff_valid = r_vld_pipe[ROM_LAT-1];
  assign bus.coeff_first = r_vld_pipe[ROM_LAT-1] & r_first_pipe[ROM_LAT-1];
  assign bus.coeff_last  = r_vld_pipe[ROM_LAT-1] & r_last_pipe[ROM_LAT-1];
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_FIN);
endmodule

// File: tb/tb_fft_coeff_seq.sv
// Scoreboard bench for fft_coeff_seq (SIZE=32, ROM_LAT=1). Stimulus pushes the
// expected read/tag/done events with their cycle numbers; a negedge monitor
// pops and compares whenever the DUT presents rom_en, coeff_valid or done.
module tb_fft_coeff_seq;
  localparam int SIZE = 32;
  localparam int AW   = 5;

  typedef struct {int cyc; int val;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_first  = 0;
  int   n_last   = 0;
  int   busy_lo  = 1;
  int   busy_hi  = 0;

  exp_t q_addr[$];
  exp_t q_tag[$];
  int   q_done[$];

  fft_coeff_seq_if #(.AW(AW)) bus ();

  fft_coeff_seq #(.SIZE(SIZE), .AW(AW), .ROM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int i);
    logic [4:0] c, r;
    c = i[4:0];
`ifdef COEFF_SEQ_BITREV_EN
    for (int b = 0; b < 5; b++) r[b] = c[4-b];
`else
    r = c;
`endif
    return int'(r);
  endfunction

  // Beat idx issued in cycle c: address at c, tag one cycle later.
  task automatic push_addr(input int c, input int idx);
    q_addr.push_back('{c, exp_addr(idx % SIZE)});
  endtask
  task automatic push_tag(input int c, input int idx);
    q_tag.push_back('{c + 1, 2 * int'(idx % SIZE == 0) + int'(idx % SIZE == SIZE - 1)});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.rom_en) begin
      if (q_addr.size() == 0) check("rom_en_unexpected", 1, 0);
      else begin
        e = q_addr.pop_front();
        check("rom_en_cycle", cyc, e.cyc);
        check("rom_addr", int'(bus.rom_addr), e.val);
      end
    end
    if (bus.coeff_valid) begin
      if (bus.coeff_first) n_first++;
      if (bus.coeff_last)  n_last++;
      if (q_tag.size() == 0) check("coeff_valid_unexpected", 1, 0);
      else begin
        e = q_tag.pop_front();
        check("coeff_valid_cycle", cyc, e.cyc);
        check("coeff_first_last", 2 * int'(bus.coeff_first) + int'(bus.coeff_last), e.val);
      end
    end else if (bus.coeff_first || bus.coeff_last) begin
      check("tag_without_valid", 1, 0);
    end
    if (bus.done) begin
      if (q_done.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, q_done.pop_front());
    end
    check("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask
  task automatic pulse_start(output int s);
    s = cyc;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_en"},      int'(bus.rom_en), 0);
    check({tag, "_rom_addr"},    int'(bus.rom_addr), 0);
    check({tag, "_coeff_valid"}, int'(bus.coeff_valid), 0);
    check({tag, "_coeff_first"}, int'(bus.coeff_first), 0);
    check({tag, "_coeff_last"},  int'(bus.coeff_last), 0);
    check({tag, "_busy"},        int'(bus.busy), 0);
    check({tag, "_done"},        int'(bus.done), 0);
  endtask

  task automatic single_frame();
    int s;
    pulse_start(s);
    for (int i = 0; i < SIZE; i++) begin
      push_addr(s + 1 + i, i);
      push_tag(s + 1 + i, i);
    end
    q_done.push_back(s + 35);
    busy_lo = s + 1; busy_hi = s + 34;
    wait_until(s + 40);
  endtask

  initial begin
    int s;
    bus.start = 1'b0; bus.hold = 1'b0; bus.cont = 1'b0;
    #3;
    check_all_zero("reset");
    #9 rst = 1'b0;
    tick(1);

    // Single frame, no hold
    single_frame();

    // Stall: hold for 3 cycles while address index 10 is presented
    pulse_start(s);
    for (int i = 0; i < SIZE; i++) begin
      push_addr(s + 1 + i + (i >= 10 ? 3 : 0), i);
      push_tag(s + 1 + i + (i >= 10 ? 3 : 0), i);
    end
    q_done.push_back(s + 38);
    busy_lo = s + 1; busy_hi = s + 37;
    wait_until(s + 11);
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_rom_en", int'(bus.rom_en), 0);
      check("hold_rom_addr", int'(bus.rom_addr), exp_addr(10));
      tick(1);
    end
    bus.hold = 1'b0;
    wait_until(s + 44);

    // Continuous: two wraps, cont cleared at index 5 of frame 3
    n_first = 0; n_last = 0;
    bus.cont = 1'b1;
    pulse_start(s);
    for (int i = 0; i < 3 * SIZE; i++) begin
      push_addr(s + 1 + i, i);
      push_tag(s + 1 + i, i);
    end
    q_done.push_back(s + 99);
    busy_lo = s + 1; busy_hi = s + 98;
    wait_until(s + 70);
    bus.cont = 1'b0;
    wait_until(s + 104);
    check("cont_first_count", n_first, 3);
    check("cont_last_count", n_last, 3);

    // Start while busy (index 7) and in FIN: both ignored
    pulse_start(s);
    for (int i = 0; i < SIZE; i++) begin
      push_addr(s + 1 + i, i);
      push_tag(s + 1 + i, i);
    end
    q_done.push_back(s + 35);
    busy_lo = s + 1; busy_hi = s + 34;
    wait_until(s + 8);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    wait_until(s + 35);
    check("fin_done", int'(bus.done), 1);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    wait_until(s + 44);

    // Async reset mid-frame while index 17 is presented
    pulse_start(s);
    for (int i = 0; i < 17; i++) push_addr(s + 1 + i, i);
    for (int i = 0; i < 16; i++) push_tag(s + 1 + i, i);
    busy_lo = s + 1; busy_hi = s + 17;
    wait_until(s + 18);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick(2);
    #3 rst = 1'b0;
    tick(2);
    check_all_zero("post_rst_idle");
    single_frame();

    check("q_addr_empty", q_addr.size(), 0);
    check("q_tag_empty", q_tag.size(), 0);
    check("q_done_empty", q_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
